// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for the single-ALU RISC-V datapath: FETCH/DECODE/EXECUTE/MEM/WB/TRAP.
// Optional performance counters (cycle_count, instret_count) are built only when SEQ_PERF_CNT_EN is defined.
module multicycle_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             dec_reg_write,
  input  logic             dec_mem_write,
  input  logic             dec_branch,
  input  logic             alu_zero,
  output logic             imem_req,
  input  logic             imem_ready,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             opnd_latch,
  output logic             alu_latch,
  output logic             mdr_latch,
  output logic             rf_we,
  output logic             illegal,
  output logic [2:0]       state_o
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count
`endif
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd5
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   retire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    retire     = 1'b0;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    opnd_latch = 1'b0;
    alu_latch  = 1'b0;
    mdr_latch  = 1'b0;
    rf_we      = 1'b0;
    illegal    = illegal_q;
    state_o    = state_q;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        opnd_latch = 1'b1;
        case (opcode)
          OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR: state_d = S_EXECUTE;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXECUTE: begin
        alu_latch = 1'b1;
        case (opcode)
          OP_BR: begin
            // Not-taken leaves the PC+4 already written during FETCH.
            pc_write = dec_branch & alu_zero;
            pc_src   = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end
          OP_LOAD, OP_STORE: state_d = S_MEM;
          OP_R, OP_I:        state_d = S_WB;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec_mem_write;
        if (dmem_ready) begin
          if (opcode == OP_LOAD) begin
            mdr_latch = 1'b1;
            state_d   = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        rf_we   = dec_reg_write;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset masks every output in the same cycle so an aborted access never commits.
    if (rst) begin
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      opnd_latch = 1'b0;
      alu_latch  = 1'b0;
      mdr_latch  = 1'b0;
      rf_we      = 1'b0;
      illegal    = 1'b0;
      state_o    = 3'd0;
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q, instret_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q <= cycle_q + 1'b1;
      if (retire) instret_q <= instret_q + 1'b1;
    end
  end

  assign cycle_count   = rst ? '0 : cycle_q;
  assign instret_count = rst ? '0 : instret_q;
`else
  logic [CNT_W-1:0] unused_cnt;
  logic             unused_retire;
  assign unused_cnt    = '0;
  assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed-vector bench for multicycle_sequencer; counter checks compile in with SEQ_PERF_CNT_EN.
module tb_multicycle_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic       dec_reg_write, dec_mem_write, dec_branch, alu_zero;
  logic       imem_req, imem_ready, dmem_req, dmem_we, dmem_ready;
  logic       ir_write, pc_write, pc_src, opnd_latch, alu_latch, mdr_latch, rf_we, illegal;
  logic [2:0] state_o;
`ifdef SEQ_PERF_CNT_EN
  logic [3:0] cycle_count, instret_count;
`endif

  int n_chk = 0;
  int n_bad = 0;

  // {imem_req, ir_write, pc_write, pc_src, opnd_latch, alu_latch, dmem_req, dmem_we, mdr_latch, rf_we, illegal}
  logic [10:0] sb;
  assign sb = {imem_req, ir_write, pc_write, pc_src, opnd_latch, alu_latch,
               dmem_req, dmem_we, mdr_latch, rf_we, illegal};

  localparam logic [10:0] SB_NONE  = 11'b00000000000;
  localparam logic [10:0] SB_FWAIT = 11'b10000000000;
  localparam logic [10:0] SB_FETCH = 11'b11100000000;
  localparam logic [10:0] SB_DEC   = 11'b00001000000;
  localparam logic [10:0] SB_EXE   = 11'b00000100000;
  localparam logic [10:0] SB_BRT   = 11'b00110100000;
  localparam logic [10:0] SB_BRN   = 11'b00010100000;
  localparam logic [10:0] SB_LDW   = 11'b00000010000;
  localparam logic [10:0] SB_LDD   = 11'b00000010100;
  localparam logic [10:0] SB_ST    = 11'b00000011000;
  localparam logic [10:0] SB_WB    = 11'b00000000010;
  localparam logic [10:0] SB_TRAP  = 11'b00000000001;

  multicycle_sequencer #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .dec_reg_write(dec_reg_write), .dec_mem_write(dec_mem_write),
    .dec_branch(dec_branch), .alu_zero(alu_zero),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .opnd_latch(opnd_latch), .alu_latch(alu_latch), .mdr_latch(mdr_latch),
    .rf_we(rf_we), .illegal(illegal), .state_o(state_o)
`ifdef SEQ_PERF_CNT_EN
    , .cycle_count(cycle_count), .instret_count(instret_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1 with inputs already set; samples one cycle later, returns at next posedge+1.
  task automatic cyc(input string tag, input logic [2:0] st, input logic [10:0] exp_sb);
    #1;
    chk({tag, ".state"}, 32'(state_o), 32'(st));
    chk({tag, ".strobes"}, 32'(sb), 32'(exp_sb));
    @(posedge clk);
    #1;
  endtask

  task automatic rst_cycle(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, ".rst_state"}, 32'(state_o), 32'd0);
    chk({tag, ".rst_strobes"}, 32'(sb), 32'(SB_NONE));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic rw, input logic mw, input logic br);
    opcode = op; dec_reg_write = rw; dec_mem_write = mw; dec_branch = br;
  endtask

  task automatic addi_instr(input string tag);
    set_instr(7'b0010011, 1'b1, 1'b0, 1'b0);
    imem_ready = 1'b1; dmem_ready = 1'b1;
    cyc({tag, ".f"}, 3'd0, SB_FETCH);
    cyc({tag, ".d"}, 3'd1, SB_DEC);
    cyc({tag, ".e"}, 3'd2, SB_EXE);
    cyc({tag, ".w"}, 3'd4, SB_WB);
  endtask

  initial begin
    rst = 1'b1; alu_zero = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
    set_instr(7'b0010011, 1'b1, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_cycle("reset");

    addi_instr("addi");

    // lw: dmem_ready high outside MEM must be ignored, then 3 wait states
    set_instr(7'b0000011, 1'b1, 1'b0, 1'b0);
    dmem_ready = 1'b1;
    cyc("lw.f", 3'd0, SB_FETCH);
    cyc("lw.d", 3'd1, SB_DEC);
    cyc("lw.e", 3'd2, SB_EXE);
    dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc($sformatf("lw.mwait%0d", i), 3'd3, SB_LDW);
    dmem_ready = 1'b1;
    cyc("lw.mdone", 3'd3, SB_LDD);
    cyc("lw.w", 3'd4, SB_WB);

    set_instr(7'b1100011, 1'b0, 1'b0, 1'b1);
    alu_zero = 1'b1;
    cyc("beqT.f", 3'd0, SB_FETCH);
    cyc("beqT.d", 3'd1, SB_DEC);
    cyc("beqT.e", 3'd2, SB_BRT);
    alu_zero = 1'b0;
    cyc("beqN.f", 3'd0, SB_FETCH);
    cyc("beqN.d", 3'd1, SB_DEC);
    cyc("beqN.e", 3'd2, SB_BRN);

    // sw with two instruction-fetch wait states
    set_instr(7'b0100011, 1'b0, 1'b1, 1'b0);
    imem_ready = 1'b0;
    cyc("sw.fw0", 3'd0, SB_FWAIT);
    cyc("sw.fw1", 3'd0, SB_FWAIT);
    imem_ready = 1'b1;
    cyc("sw.f", 3'd0, SB_FETCH);
    cyc("sw.d", 3'd1, SB_DEC);
    cyc("sw.e", 3'd2, SB_EXE);
    cyc("sw.m", 3'd3, SB_ST);

    // sw aborted by reset while waiting in MEM
    cyc("swr.f", 3'd0, SB_FETCH);
    cyc("swr.d", 3'd1, SB_DEC);
    cyc("swr.e", 3'd2, SB_EXE);
    dmem_ready = 1'b0;
    cyc("swr.mwait", 3'd3, SB_ST);
    rst_cycle("swr");
    dmem_ready = 1'b1;
    cyc("swr.refetch", 3'd0, SB_FETCH);
    cyc("swr.d2", 3'd1, SB_DEC);
    cyc("swr.e2", 3'd2, SB_EXE);
    cyc("swr.m2", 3'd3, SB_ST);

    // illegal opcode; hostile inputs while trapped must not produce strobes
    set_instr(7'b1111111, 1'b1, 1'b1, 1'b1);
    alu_zero = 1'b1;
    cyc("ill.f", 3'd0, SB_FETCH);
    cyc("ill.d", 3'd1, SB_DEC);
    for (int i = 0; i < 11; i++) cyc($sformatf("ill.trap%0d", i), 3'd5, SB_TRAP);
    alu_zero = 1'b0;
    rst_cycle("ill");
`ifdef SEQ_PERF_CNT_EN
    chk("perf.cyc0", 32'(cycle_count), 32'd0);
    chk("perf.ins0", 32'(instret_count), 32'd0);
`endif
    for (int i = 0; i < 5; i++) addi_instr($sformatf("perf%0d", i));
`ifdef SEQ_PERF_CNT_EN
    #1;
    chk("perf.cycle_count", 32'(cycle_count), 32'd4);
    chk("perf.instret_count", 32'(instret_count), 32'd5);
`endif
    cyc("end.f", 3'd0, SB_FETCH);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
